// File: rtl/writeback_regfile_pkg.sv
// Shared widths, architectural register indices and the write-back payload type.
package writeback_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  // One register-file write request as seen by the array and the hazard unit.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_wr_t;

  // Write-data priority: link address, then load data, then ALU/HI-LO result.
  function automatic logic [DATA_W-1:0] wb_sel_data(
    input logic              jal,
    input logic              dm2reg,
    input logic [DATA_W-1:0] pc_plus4,
    input logic [DATA_W-1:0] rd_dm,
    input logic [DATA_W-1:0] hilo
  );
    if (jal)         return DATA_W'(pc_plus4 + DATA_W'(4));
    else if (dm2reg) return rd_dm;
    else             return hilo;
  endfunction

endpackage

// File: rtl/writeback_regfile_core.sv
// 31-entry register array with one write port and three write-first bypassed read ports.
module regfile_core
  import writeback_regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  wb_wr_t            wr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3
);

  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];

  // Register 0 is not stored; a write to it is dropped here as a second guard.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input wb_wr_t            w,
    input logic [DATA_W-1:0] stored
  );
    if (ra == REG_ZERO)              return '0;
    else if (w.we && (ra == w.wa))   return w.wd;
    else                             return stored;
  endfunction

  // Next array contents: copy, then overlay the single write.
  always_comb begin
    for (int i = 1; i < 32; i++) regs_d[i] = regs_q[i];
    if (wr.we && (wr.wa != REG_ZERO)) regs_d[wr.wa] = wr.wd;
  end

  // Array state; reset clears everything except the stack pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      regs_q[REG_SP] <= SP_INIT;
    end else begin
      for (int i = 1; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Combinational read ports; ra = 0 selects a don't-care stored entry that is masked.
  always_comb begin
    rd1 = read_port(ra1, wr, (ra1 == REG_ZERO) ? '0 : regs_q[ra1]);
    rd2 = read_port(ra2, wr, (ra2 == REG_ZERO) ? '0 : regs_q[ra2]);
    rd3 = read_port(ra3, wr, (ra3 == REG_ZERO) ? '0 : regs_q[ra3]);
  end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: selects write data/address, drives the register file,
// exports forwarding info and counts retired instructions.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_WB,
  input  logic              we_reg_WB,
  input  logic              dm2reg_WB,
  input  logic              jal_WB,
  input  logic [ADDR_W-1:0] rf_wa_WB,
  input  logic [DATA_W-1:0] rd_dm_WB,
  input  logic [DATA_W-1:0] hilo_mux_out_WB,
  input  logic [DATA_W-1:0] pc_plus4_WB,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  output logic              wb_we_fwd,
  output logic [ADDR_W-1:0] wb_wa_fwd,
  output logic [DATA_W-1:0] wb_wd_fwd,
  output logic [DATA_W-1:0] retired_cnt
);

  wb_wr_t            wr_c;
  logic [ADDR_W-1:0] eff_wa_c;
  logic [DATA_W-1:0] eff_wd_c;
  logic [DATA_W-1:0] retired_cnt_q;
  logic [DATA_W-1:0] retired_cnt_d;

  // Effective write request; jal forces the link register, r0 writes are suppressed.
  always_comb begin
    eff_wa_c = jal_WB ? REG_RA : rf_wa_WB;
    eff_wd_c = wb_sel_data(jal_WB, dm2reg_WB, pc_plus4_WB, rd_dm_WB, hilo_mux_out_WB);
    wr_c.we  = valid_WB && we_reg_WB && (eff_wa_c != REG_ZERO);
    wr_c.wa  = eff_wa_c;
    wr_c.wd  = eff_wd_c;
  end

  // Forwarding copies, zeroed when nothing is written.
  always_comb begin
    wb_we_fwd = wr_c.we;
    wb_wa_fwd = wr_c.we ? wr_c.wa : '0;
    wb_wd_fwd = wr_c.we ? wr_c.wd : '0;
  end

  // Retire counter advances on every live WB slot, wrapping naturally.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (valid_WB) retired_cnt_d = DATA_W'(retired_cnt_q + DATA_W'(1));
  end

  // Retire counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_cnt_q <= '0;
    else     retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;

  regfile_core #(
    .SP_INIT (SP_INIT)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .wr  (wr_c),
    .ra1 (ra1),
    .ra2 (ra2),
    .ra3 (ra3),
    .rd1 (rd1),
    .rd2 (rd2),
    .rd3 (rd3)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized + directed bench for writeback_regfile against an array-based model.
module tb_writeback_regfile;

  localparam logic [31:0] SP_INIT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_WB, we_reg_WB, dm2reg_WB, jal_WB;
  logic [4:0]  rf_wa_WB;
  logic [31:0] rd_dm_WB, hilo_mux_out_WB, pc_plus4_WB;
  logic [4:0]  ra1, ra2, ra3;
  logic [31:0] rd1, rd2, rd3;
  logic        wb_we_fwd;
  logic [4:0]  wb_wa_fwd;
  logic [31:0] wb_wd_fwd;
  logic [31:0] retired_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [0:31];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  writeback_regfile #(.SP_INIT(SP_INIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_WB        (valid_WB),
    .we_reg_WB       (we_reg_WB),
    .dm2reg_WB       (dm2reg_WB),
    .jal_WB          (jal_WB),
    .rf_wa_WB        (rf_wa_WB),
    .rd_dm_WB        (rd_dm_WB),
    .hilo_mux_out_WB (hilo_mux_out_WB),
    .pc_plus4_WB     (pc_plus4_WB),
    .ra1             (ra1),
    .ra2             (ra2),
    .ra3             (ra3),
    .rd1             (rd1),
    .rd2             (rd2),
    .rd3             (rd3),
    .wb_we_fwd       (wb_we_fwd),
    .wb_wa_fwd       (wb_wa_fwd),
    .wb_wd_fwd       (wb_wd_fwd),
    .retired_cnt     (retired_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model view of the current write request.
  function automatic logic [4:0] m_wa();
    return jal_WB ? 5'd31 : rf_wa_WB;
  endfunction

  function automatic logic [31:0] m_wd();
    if (jal_WB)         return pc_plus4_WB + 32'd4;
    else if (dm2reg_WB) return rd_dm_WB;
    else                return hilo_mux_out_WB;
  endfunction

  function automatic logic m_wen();
    return valid_WB && we_reg_WB && (m_wa() != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (m_wen() && ra == m_wa()) return m_wd();
    return m_reg[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_reg[29] = SP_INIT;
    m_cnt = 32'd0;
  endtask

  task automatic check_all();
    check_eq("rd1", rd1, m_read(ra1));
    check_eq("rd2", rd2, m_read(ra2));
    check_eq("rd3", rd3, m_read(ra3));
    check_eq("we_fwd", {31'd0, wb_we_fwd}, {31'd0, m_wen()});
    check_eq("wa_fwd", {27'd0, wb_wa_fwd}, m_wen() ? {27'd0, m_wa()} : 32'd0);
    check_eq("wd_fwd", wb_wd_fwd, m_wen() ? m_wd() : 32'd0);
    check_eq("retired", retired_cnt, m_cnt);
  endtask

  // Called at a negedge with inputs applied: check, clock, commit model.
  task automatic run_cycle();
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        v;
    #1;
    check_all();
    wen = m_wen(); wa = m_wa(); wd = m_wd(); v = valid_WB;
    @(posedge clk);
    if (wen) m_reg[wa] = wd;
    if (v) m_cnt = m_cnt + 32'd1;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic dm, input logic jal,
                       input logic [4:0] wa, input logic [31:0] dmd, input logic [31:0] hilo,
                       input logic [31:0] pc);
    valid_WB = v; we_reg_WB = we; dm2reg_WB = dm; jal_WB = jal;
    rf_wa_WB = wa; rd_dm_WB = dmd; hilo_mux_out_WB = hilo; pc_plus4_WB = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [31:0] seq [0:2];
    logic [31:0] saved;
    seq[0] = 32'hFFFF_FFFF; seq[1] = 32'h0000_0000; seq[2] = 32'h0000_0001;

    rst = 1'b1;
    idle();
    ra1 = 5'd29; ra2 = 5'd5; ra3 = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_sp", rd1, 32'h0000_0100);
    check_eq("reset_r5", rd2, 32'd0);
    check_eq("reset_cnt", retired_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bypass on same-cycle read, then stored value after the edge.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'd0, 32'hDEAD_BEEF, 32'd0);
    ra1 = 5'd7; ra2 = 5'd7; ra3 = 5'd7;
    #1;
    check_eq("bypass_rd1", rd1, 32'hDEAD_BEEF);
    check_eq("bypass_wefwd", {31'd0, wb_we_fwd}, 32'd1);
    check_eq("bypass_wafwd", {27'd0, wb_wa_fwd}, 32'd7);
    #1 run_cycle();
    idle();
    #1;
    check_eq("stored_r7", rd1, 32'hDEAD_BEEF);
    check_eq("same_rd2", rd2, rd1);
    check_eq("same_rd3", rd3, rd1);
    #1 run_cycle();

    // jal overrides load data and destination address.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1234_5678, 32'd0, 32'h0040_0010);
    run_cycle();
    idle();
    ra1 = 5'd31; ra2 = 5'd3;
    #1;
    check_eq("jal_r31", rd1, 32'h0040_0014);
    check_eq("jal_r3", rd2, 32'd0);
    #1 run_cycle();

    // Write to r0 is discarded.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
    ra1 = 5'd0;
    #1;
    check_eq("r0_rd", rd1, 32'd0);
    check_eq("r0_wefwd", {31'd0, wb_we_fwd}, 32'd0);
    #1 run_cycle();

    // Not valid: no write, no count.
    saved = retired_cnt;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'd0, 32'h0000_00AA, 32'd0);
    ra1 = 5'd5;
    run_cycle();
    idle();
    #1;
    check_eq("inval_r5", rd1, 32'd0);
    check_eq("inval_cnt", retired_cnt, saved);
    #1;

    // Counter wrap from a forced near-max value.
    force dut.retired_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.retired_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0, 32'd0, 32'd0);
      run_cycle();
      check_eq("wrap_seq", retired_cnt, seq[i]);
    end

    // Reset held across a write edge discards the write.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'd0, 32'h0000_0099, 32'd0);
    ra1 = 5'd9; ra2 = 5'd29;
    #2 rst = 1'b1;
    @(negedge clk);
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_r9", rd1, 32'd0);
    check_eq("rst_sp", rd2, SP_INIT);
    check_eq("rst_cnt", retired_cnt, 32'd0);
    #1 run_cycle();
    #1;
    check_eq("post_rst_r9", rd1, 32'd0);
    #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            rand_addr(), $urandom(), $urandom(),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom());
      ra1 = rand_addr(); ra2 = rand_addr();
      ra3 = ($urandom_range(0, 1) == 0) ? ra1 : rand_addr();
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
